ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
- Single-channel WS2812 one-wire receiver/decoder on the 6502 IO bus, 4-byte register window.
- Measures high-pulse widths on a WS2812-style input and decodes bits (GRB order, MSB first).
- Captures the first 24-bit pixel after each reset/latch gap and exposes it as R/G/B registers with status and interrupt.
- Used for loopback test of the LED core's WS2812 output and for chained-pixel input.

Parameters:
- CLK_FRE, 27_000_000: clock frequency in Hz (informational; cycle parameters below are authoritative).
- MIN_HIGH_CYC, 4: high pulses shorter than this are a glitch error.
- THRESH_CYC, 16: high pulse of this many cycles or more decodes as 1, otherwise 0 (about 0.6 us).
- MAX_HIGH_CYC, 40: high pulse exceeding this is a stuck-high error.
- RESET_CYC, 1350: low time that counts as a frame reset/latch gap (50 us).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- R_W_n  in  1  bus direction, 1 = read, 0 = write.
- reg_addr_i  in  2  register select.
- data_i  in  8  write data.
- rx_cs  in  1  chip select for this register window.
- data_o  out  8  read data (combinational mux on reg_addr_i).
- ws2812_i  in  1  asynchronous serial input.
- ws2812_o  out  1  forwarded stream (see Optional Feature).
- irq_o  out  1  level interrupt.

Behaviour:
- Registers:
  - 00 STAT: bit0 VALID, bit1 OVR, bit2 ERR, bit6 IRQEN, bit7 EN. Writing 1 to bit0/1/2 clears that bit; bits 6/7 are written directly.
  - 01 R, 02 G, 03 B: read-only captured pixel; writes are ignored.
- Reset values: all registers 0, state SYNC, data_o = 0 (STAT selected), ws2812_o = 0, irq_o = 0.
- Input path:
  - 2-flop synchroniser on ws2812_i; edge detection on the synchronised value.
  - Decode decisions occur 3 cycles after a pin edge.
- Counters:
  - 16-bit pulse counter, saturating.
  - 5-bit bit counter.
  - 24-bit shift register, shifted left with each new bit in at LSB.
- FSM states:
  - SYNC: counter runs while input low and clears when high. Counter reaching RESET_CYC goes to GAP. Entered whenever EN=0; holds while EN=0.
  - GAP: bit count = 0; rising edge goes to HIGH.
  - HIGH: count cycles.
    - Counter > MAX_HIGH_CYC goes to SYNC and sets ERR.
    - Falling edge with count < MIN_HIGH_CYC goes to SYNC and sets ERR.
    - Otherwise bit = (count >= THRESH_CYC); go to LOW.
  - LOW: count cycles.
    - Rising edge goes to HIGH.
    - Count reaching RESET_CYC goes to GAP. If the bit count is between 1 and 23 (partial pixel), set ERR.
- Capture:
  - On the 24th decoded bit of a frame, registers load {G,R,B} = shift[23:0] in the same cycle and VALID sets.
  - If VALID was already 1, OVR also sets and the data is overwritten.
- Bits 25 and later in a frame are discarded; the bit counter saturates at 24 (pixel_done).
- Same-cycle hardware set and CPU clear of a status bit: set wins.
- irq_o = VALID & IRQEN, registered (1 cycle after VALID).
- EN cleared mid-frame: state goes to SYNC and the bit count clears. R/G/B and status flags are retained.
- A frame only starts after a full RESET_CYC low gap has been seen since enable or since an error.

Optional Feature:
- Macro WS2812_RX_FORWARD_EN.
- Defined: ws2812_o = synchronised input gated by pixel_done. Bits after the first 24 of a frame are passed through with 2-cycle latency, as in a daisy-chained pixel. ws2812_o is forced to 0 when pixel_done is clear or EN=0.
- Undefined: ws2812_o is tied to 0.

Decomposition:
- Package ws2812_pkg holds:
  - register addresses (STAT/R/G/B);
  - STAT bit indices;
  - FSM state encoding (SYNC, GAP, HIGH, LOW);
  - the default timing constants, shared with the LED core.
- One sub-module, ws2812_pulse_meter: synchroniser, edge detect and saturating pulse counter. It outputs rise/fall strobes and the count.
- FSM and registers stay in ws2812_rx.

Test Plan:
- EN=1, 1400-cycle low gap, then 24 bits of 0x12,0x34,0x56 (1 = 23 high/11 low, 0 = 11 high/23 low) -> G=0x12, R=0x34, B=0x56, STAT=0x81; irq_o stays 0 with IRQEN=0.
- Same frame with IRQEN=1, second frame sent without clearing VALID -> OVR=1, new data visible, irq_o=1. Write 0x07|0xC0 -> STAT=0xC0, irq_o=0 next cycle.
- 2-cycle high glitch mid-frame -> ERR=1, no capture, state SYNC. Next frame is ignored until a 1350-cycle gap, then decodes correctly.
- 10 bits followed by a 1400-cycle gap -> ERR=1, VALID=0. Input held high for 50 cycles -> ERR=1.
- 48-bit frame with FORWARD_EN defined -> first pixel captured; ws2812_o mirrors bits 25–48 delayed 2 cycles and is 0 during bits 1–24. With the macro undefined, ws2812_o is constantly 0.
- rst_n_i asserted mid-bit -> all registers 0 and ws2812_o = 0 asynchronously.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 receiver: register map, status bit
// positions, receiver state encoding and the default pulse timing constants
// that the LED transmitter core uses as well.
package ws2812_pkg;

  // Default timing, in system clock cycles at 27 MHz
  localparam int DEF_CLK_FRE      = 27_000_000;
  localparam int DEF_MIN_HIGH_CYC = 4;     // shorter high pulse is a glitch
  localparam int DEF_THRESH_CYC   = 16;    // >= this many cycles decodes as 1
  localparam int DEF_MAX_HIGH_CYC = 40;    // longer high pulse is stuck-high
  localparam int DEF_RESET_CYC    = 1350;  // 50 us low = reset/latch gap

  // Register window
  localparam logic [1:0] ADDR_STAT = 2'd0;
  localparam logic [1:0] ADDR_R    = 2'd1;
  localparam logic [1:0] ADDR_G    = 2'd2;
  localparam logic [1:0] ADDR_B    = 2'd3;

  // STAT bit positions
  localparam int STAT_VALID = 0;
  localparam int STAT_OVR   = 1;
  localparam int STAT_ERR   = 2;
  localparam int STAT_IRQEN = 6;
  localparam int STAT_EN    = 7;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    GAP  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ws2812_pulse_meter.sv
// Input conditioning for the WS2812 receiver: two-flop synchroniser,
// rise/fall strobes and a saturating count of cycles since the last edge.
// On an edge the count restarts at 1, so at a strobe it equals the width of
// the level that just ended.
module ws2812_pulse_meter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  input  logic        clr,
  output logic        level,
  output logic        rise,
  output logic        fall,
  output logic [15:0] count
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronise the pin and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

  // Saturating width counter, restarted on every edge, held at 0 by clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (clr) begin
      count <= 16'd0;
    end else if (rise || fall) begin
      count <= 16'd1;
    end else if (count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 one-wire receiver on the 6502 IO bus. Decodes GRB pixels from
// high-pulse widths, captures the first pixel after each latch gap into the
// R/G/B registers and reports VALID/OVR/ERR with a level interrupt.
// Optional build macro WS2812_RX_FORWARD_EN: when defined, bits after the
// first 24 of a frame are forwarded on ws2812_o; otherwise ws2812_o is 0.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int MIN_HIGH_CYC = DEF_MIN_HIGH_CYC,
  parameter int THRESH_CYC   = DEF_THRESH_CYC,
  parameter int MAX_HIGH_CYC = DEF_MAX_HIGH_CYC,
  parameter int RESET_CYC    = DEF_RESET_CYC
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       R_W_n,
  input  logic [1:0] reg_addr_i,
  input  logic [7:0] data_i,
  input  logic       rx_cs,
  output logic [7:0] data_o,
  input  logic       ws2812_i,
  output logic       ws2812_o,
  output logic       irq_o
);

  localparam logic [15:0] MIN_C = 16'(MIN_HIGH_CYC);
  localparam logic [15:0] THR_C = 16'(THRESH_CYC);
  localparam logic [15:0] MAX_C = 16'(MAX_HIGH_CYC);
  localparam logic [15:0] RST_C = 16'(RESET_CYC);

  rx_state_t   state;
  logic        en, irqen, valid, ovr, err, irq;
  logic [4:0]  bit_cnt;
  logic [23:0] shift;
  logic [7:0]  r, g, b;
  logic        level, rise, fall, meter_clr;
  logic [15:0] count;
  logic        stat_wr, pixel_done, bit_val;
  logic [23:0] shift_in;
  logic [7:0]  stat;
  logic        unused_data;

  assign meter_clr = ~en;

  ws2812_pulse_meter u_meter (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .din   (ws2812_i),
    .clr   (meter_clr),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .count (count)
  );

  assign stat_wr     = rx_cs & ~R_W_n & (reg_addr_i == ADDR_STAT);
  assign pixel_done  = (bit_cnt == 5'd24);
  assign bit_val     = (count >= THR_C);
  assign shift_in    = {shift[22:0], bit_val};
  assign unused_data = ^data_i[5:3];
  assign irq_o       = irq;

  // Bus writes, decode FSM, capture and status flags (hardware sets are
  // written after CPU clears so a same-cycle set wins)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= SYNC;
      en      <= 1'b0;
      irqen   <= 1'b0;
      valid   <= 1'b0;
      ovr     <= 1'b0;
      err     <= 1'b0;
      irq     <= 1'b0;
      bit_cnt <= 5'd0;
      shift   <= 24'd0;
      r       <= 8'd0;
      g       <= 8'd0;
      b       <= 8'd0;
    end else begin
      irq <= valid & irqen;
      if (stat_wr) begin
        en    <= data_i[STAT_EN];
        irqen <= data_i[STAT_IRQEN];
        if (data_i[STAT_VALID]) valid <= 1'b0;
        if (data_i[STAT_OVR])   ovr   <= 1'b0;
        if (data_i[STAT_ERR])   err   <= 1'b0;
      end
      if (!en) begin
        state   <= SYNC;
        bit_cnt <= 5'd0;
      end else begin
        case (state)
          SYNC: begin
            bit_cnt <= 5'd0;
            if (!level && count >= RST_C) state <= GAP;
          end
          GAP: begin
            bit_cnt <= 5'd0;
            if (rise) state <= HIGH;
          end
          HIGH: begin
            if (count > MAX_C) begin
              state   <= SYNC;
              err     <= 1'b1;
              bit_cnt <= 5'd0;
            end else if (fall) begin
              if (count < MIN_C) begin
                state   <= SYNC;
                err     <= 1'b1;
                bit_cnt <= 5'd0;
              end else begin
                state <= LOW;
                if (!pixel_done) begin
                  shift   <= shift_in;
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd23) begin
                    g     <= shift_in[23:16];
                    r     <= shift_in[15:8];
                    b     <= shift_in[7:0];
                    valid <= 1'b1;
                    if (valid) ovr <= 1'b1;
                  end
                end
              end
            end
          end
          LOW: begin
            if (rise) begin
              state <= HIGH;
            end else if (count >= RST_C) begin
              state <= GAP;
              if (bit_cnt != 5'd0 && !pixel_done) err <= 1'b1;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

  // Register read mux
  always_comb begin
    stat             = 8'h00;
    stat[STAT_VALID] = valid;
    stat[STAT_OVR]   = ovr;
    stat[STAT_ERR]   = err;
    stat[STAT_IRQEN] = irqen;
    stat[STAT_EN]    = en;
    case (reg_addr_i)
      ADDR_STAT: data_o = stat;
      ADDR_R:    data_o = r;
      ADDR_G:    data_o = g;
      ADDR_B:    data_o = b;
      default:   data_o = 8'h00;
    endcase
  end

`ifdef WS2812_RX_FORWARD_EN
  // Pass the synchronised stream through once this pixel's 24 bits are taken
  assign ws2812_o = level & pixel_done & en;
`else
  logic unused_fwd;
  assign unused_fwd = level;
  assign ws2812_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: randomized pixel frames, glitch,
// stuck-high, partial-frame and reset scenarios. A behavioural model tracks
// expected register contents; readbacks feed a scoreboard monitor.
module tb_ws2812_rx;

  localparam int MIN_H = 4;
  localparam int THR   = 16;
  localparam int MAX_H = 40;
`ifdef WS2812_RX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  stat;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        irq;
    logic        wo;
    logic [31:0] fwd;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rw = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic       cs = 1'b0;
  logic       pin = 1'b0;
  logic [7:0] data_o;
  logic       ws2812_o;
  logic       irq_o;

  ws2812_rx dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .R_W_n      (rw),
    .reg_addr_i (addr),
    .data_i     (wdata),
    .rx_cs      (cs),
    .data_o     (data_o),
    .ws2812_i   (pin),
    .ws2812_o   (ws2812_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_en, m_irqen, m_valid, m_ovr, m_err, m_synced;
  int          m_bits, m_pix;
  logic [31:0] m_fwd;
  logic [7:0]  m_r, m_g, m_b;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  bit   stim_done = 1'b0;
  bit   drain_checked = 1'b0;
  logic [31:0] fwd_total = 0;
  logic [31:0] fwd_snap = 0;

  // Count forwarded high cycles
  always @(negedge clk) if (ws2812_o === 1'b1) fwd_total <= fwd_total + 1;

  task automatic model_reset();
    m_en = 0; m_irqen = 0; m_valid = 0; m_ovr = 0; m_err = 0; m_synced = 0;
    m_bits = 0; m_pix = 0; m_fwd = 0; m_r = 0; m_g = 0; m_b = 0;
  endtask

  task automatic model_write(input logic [7:0] d);
    if (d[0]) m_valid = 0;
    if (d[1]) m_ovr = 0;
    if (d[2]) m_err = 0;
    if (!d[7] || !m_en) begin m_synced = 0; m_bits = 0; end
    m_en = d[7];
    m_irqen = d[6];
  endtask

  task automatic model_bit(input int h);
    if (m_en && m_synced) begin
      if (h < MIN_H || h > MAX_H) begin
        m_err = 1; m_synced = 0; m_bits = 0;
      end else if (m_bits < 24) begin
        m_pix = m_pix * 2 + ((h >= THR) ? 1 : 0);
        m_bits++;
        if (m_bits == 24) begin
          if (m_valid) m_ovr = 1;
          m_valid = 1;
          m_g = 8'((m_pix / 65536) % 256);
          m_r = 8'((m_pix / 256) % 256);
          m_b = 8'(m_pix % 256);
        end
      end else if (FWD) begin
        m_fwd = m_fwd + 32'(h);
      end
    end
  endtask

  task automatic model_gap();
    if (m_en) begin
      if (m_synced && m_bits > 0 && m_bits < 24) m_err = 1;
      m_synced = 1; m_bits = 0; m_pix = 0;
    end
  endtask

  function automatic rec_t model_rec();
    rec_t e;
    e.stat = {m_en, m_irqen, 3'b000, m_err, m_ovr, m_valid};
    e.r = m_r; e.g = m_g; e.b = m_b;
    e.irq = m_valid & m_irqen;
    e.wo = 1'b0;
    e.fwd = m_fwd;
    return e;
  endfunction

  task automatic bus_write(input logic [7:0] d);
    @(negedge clk); cs = 1; rw = 0; addr = 2'd0; wdata = d;
    @(negedge clk); cs = 0; rw = 1;
    model_write(d);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk); cs = 1; rw = 1; addr = a;
    #1 v = data_o;
    cs = 0; addr = 2'd0;
  endtask

  task automatic pin_bit(input int h, input int l);
    model_bit(h);
    pin = 1'b1; repeat (h) @(negedge clk);
    pin = 1'b0; repeat (l) @(negedge clk);
  endtask

  task automatic pin_gap(input int n);
    model_gap();
    pin = 1'b0; repeat (n) @(negedge clk);
  endtask

  // mode 0: nominal widths, 1: random widths, 2: threshold boundary widths
  task automatic send_bits(input logic [47:0] data, input int n, input int mode);
    logic bv;
    int h, l;
    for (int i = n - 1; i >= 0; i--) begin
      bv = data[i];
      case (mode)
        0: begin h = bv ? 23 : 11; l = bv ? 11 : 23; end
        1: begin
          h = bv ? int'($urandom_range(40, 16)) : int'($urandom_range(15, 4));
          l = int'($urandom_range(40, 3));
        end
        default: begin
          h = bv ? (((i % 2) != 0) ? 40 : 16) : (((i % 2) != 0) ? 15 : 4);
          l = 12;
        end
      endcase
      pin_bit(h, l);
    end
  endtask

  task automatic readback();
    rec_t o;
    repeat (3) @(negedge clk);
    o.irq = irq_o;
    o.wo = ws2812_o;
    read_reg(2'd0, o.stat);
    read_reg(2'd1, o.r);
    read_reg(2'd2, o.g);
    read_reg(2'd3, o.b);
    o.fwd = fwd_total - fwd_snap;
    fwd_snap = fwd_total;
    exp_q.push_back(model_rec());
    m_fwd = 0;
    obs_q.push_back(o);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s (txn %0d): got %0h, expected %0h", name, txn, act, expv);
    end
  endtask

  // Scoreboard monitor: compare each presented readback with its expectation
  always @(negedge clk) begin
    rec_t o, e;
    if (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      $display("txn %0d stat=%02h g=%02h r=%02h b=%02h irq=%0b fwd=%0d", txn,
               o.stat, o.g, o.r, o.b, o.irq, o.fwd);
      cmp("stat", 32'(o.stat), 32'(e.stat));
      cmp("red", 32'(o.r), 32'(e.r));
      cmp("green", 32'(o.g), 32'(e.g));
      cmp("blue", 32'(o.b), 32'(e.b));
      cmp("irq", 32'(o.irq), 32'(e.irq));
      cmp("ws2812_o", 32'(o.wo), 32'(e.wo));
      cmp("fwd_cycles", o.fwd, e.fwd);
      txn++;
    end else if (stim_done && !drain_checked) begin
      drain_checked = 1'b1;
      cmp("drain", 32'(exp_q.size() + obs_q.size()), 32'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] d;
    rec_t ro;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    readback();

    // Nominal frame, IRQEN off
    bus_write(8'h80);
    pin_gap(1400);
    d = 48'h123456;
    send_bits(d, 24, 0);
    pin_gap(1400);
    readback();

    // IRQEN on, two frames without clearing VALID, then clear
    bus_write(8'hC7);
    d = 48'h123456;
    send_bits(d, 24, 0);
    pin_gap(1400);
    readback();
    d = {24'd0, 24'($urandom)};
    send_bits(d, 24, 1);
    pin_gap(1400);
    readback();
    bus_write(8'hC7);
    readback();

    // Random frames, boundary widths on the first
    for (int i = 0; i < 6; i++) begin
      bus_write(($urandom_range(1, 0) != 0) ? 8'hC7 : 8'hC0);
      d = {24'd0, 24'($urandom)};
      send_bits(d, 24, (i == 0) ? 2 : 1);
      pin_gap(1400);
      readback();
    end

    // Glitch mid-frame, following frame ignored until a full gap
    bus_write(8'hC7);
    d = {24'd0, 24'($urandom)};
    send_bits(d, 8, 1);
    pin_bit(2, 20);
    send_bits(d, 10, 1);
    d = {24'd0, 24'($urandom)};
    send_bits(d, 24, 1);
    pin_gap(1400);
    readback();
    d = {24'd0, 24'($urandom)};
    send_bits(d, 24, 1);
    pin_gap(1400);
    readback();

    // Partial pixel followed by a gap
    bus_write(8'hC7);
    d = {24'd0, 24'($urandom)};
    send_bits(d, 10, 1);
    pin_gap(1400);
    readback();

    // Illegal high widths around the limits
    for (int k = 0; k < 4; k++) begin
      int hw;
      hw = (k == 0) ? 2 : (k == 1) ? 3 : (k == 2) ? 41 : 50;
      bus_write(8'hC7);
      d = {24'd0, 24'($urandom)};
      send_bits(d, 3, 1);
      pin_bit(hw, 20);
      pin_gap(1400);
      readback();
    end

    // Chained 48-bit frame: first pixel captured, rest forwarded
    bus_write(8'hC7);
    d = {24'($urandom), 24'($urandom)};
    send_bits(d, 48, 1);
    pin_gap(1400);
    readback();

    // Reset asserted mid-bit with irq active
    bus_write(8'hC0);
    d = {24'd0, 24'($urandom)};
    send_bits(d, 5, 1);
    pin = 1'b1;
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    ro.stat = data_o;
    ro.irq = irq_o;
    ro.wo = ws2812_o;
    read_reg(2'd1, ro.r);
    read_reg(2'd2, ro.g);
    read_reg(2'd3, ro.b);
    pin = 1'b0;
    ro.fwd = fwd_total - fwd_snap;
    fwd_snap = fwd_total;
    model_reset();
    exp_q.push_back(model_rec());
    obs_q.push_back(ro);
    @(negedge clk);
    rst_n = 1'b1;
    readback();

    stim_done = 1'b1;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
